// File: rtl/mem_responder.sv
// Purpose : word-addressed RAM responder for a multicycle core; one request
//           at a time over valid/ready, response over a second valid/ready.
// Latency : resp_valid rises WAIT_CYCLES edges after the accepting edge.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports   : clk, reset (async, active-low); req_valid/req_ready/req_write/
//           req_addr/req_wdata/req_be (request); resp_valid/resp_ready/
//           resp_rdata/resp_err (response).
module mem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the access commits on the accepting edge itself, so the
  // request fields come straight from the ports; otherwise from the latches.
  logic            acc_wr;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;
  logic            commit;
  logic            mem_we;

  always_comb begin
    acc_wr    = (state_q == S_IDLE) ? req_write : wr_q;
    acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
  end

  // Full-width range check: high address bits are never ignored (no aliasing).
  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_idx = acc_addr[AW+1:2];

  // The RAM access happens on the edge that moves the FSM into RESP.
  assign commit = (state_d == S_RESP) && (state_q != S_RESP);
  // Reset gating keeps a WAIT_CYCLES=0 request from writing while in reset.
  assign mem_we = commit && acc_wr && !acc_err && reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_wr) ? 32'h0 : mem[acc_idx];
    end else if (state_q == S_RESP && resp_ready) begin
      rdata_d = 32'h0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // RAM contents survive reset.
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
